// File: rtl/game_select_pkg.sv
// game_select_pkg: state encoding, counter-width helper and default timing shared by the game-select key path
package game_select_pkg;
   typedef enum logic [1:0] {IDLE, FIRE, LOCK} state_t;
   localparam int DEF_DEBOUNCE_CYCLES = 500000;
   localparam int DEF_LOCKOUT_CYCLES  = 50000;
   localparam int DEF_REPEAT_DELAY    = 25000000;
   localparam int DEF_REPEAT_PERIOD   = 12500000;
   function automatic int cnt_w(int n);
      return n < 1 ? 1 : $clog2(n + 1);
   endfunction
endpackage

// File: rtl/button_debouncer.sv
// button_debouncer: two-flop synchroniser plus stable-count debouncer for an active-low key
module button_debouncer
   import game_select_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_n,
   output logic level
);
   localparam int CW = cnt_w(DEBOUNCE_CYCLES);
   logic s1, s2, db_n;
   logic [CW-1:0] cnt;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         s1   <= 1'b1;
         s2   <= 1'b1;
         db_n <= 1'b1;
         cnt  <= '0;
      end else begin
         s1 <= btn_n;
         s2 <= s1;
         if (s2 == db_n) cnt <= '0;
         else if (cnt >= CW'(DEBOUNCE_CYCLES - 1)) begin
            db_n <= s2;
            cnt  <= '0;
         end else cnt <= cnt + 1'b1;
      end
   assign level = ~db_n;
endmodule

// File: rtl/game_select_button.sv
// game_select_button: one clean count strobe per debounced press, followed by a lockout window.
// Define GAME_SELECT_AUTOREPEAT_EN to add hold-to-repeat strobes.
module game_select_button
   import game_select_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int LOCKOUT_CYCLES  = DEF_LOCKOUT_CYCLES
`ifdef GAME_SELECT_AUTOREPEAT_EN
   ,
   parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
   parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
`endif
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_n,
   output logic count,
   output logic busy,
   output logic pressed
);
   localparam int LW = cnt_w(LOCKOUT_CYCLES);
   state_t state, state_nx;
   logic level, level_q, req, expire, pending, pending_nx;
   logic [LW-1:0] lock_cnt, lock_cnt_nx;

   button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debouncer (
      .clk   (clk),
      .rst_n (rst_n),
      .btn_n (btn_n),
      .level (level)
   );

`ifdef GAME_SELECT_AUTOREPEAT_EN
   localparam int RW = cnt_w(REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD);
   logic [RW-1:0] rep_cnt;
   logic rep_mode, rep_req;
   // rep_cnt holds cycles since the last FIRE; zero means the timer is parked
   assign rep_req = level && rep_cnt != '0 &&
                    rep_cnt >= RW'((rep_mode ? REPEAT_PERIOD : REPEAT_DELAY) - 1);
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         rep_cnt  <= '0;
         rep_mode <= 1'b0;
      end else if (!level) begin
         rep_cnt  <= '0;
         rep_mode <= 1'b0;
      end else if (state == FIRE) rep_cnt <= RW'(1);
      else if (rep_req) begin
         rep_cnt  <= '0;
         rep_mode <= 1'b1;
      end else if (rep_cnt != '0 && rep_cnt != '1) rep_cnt <= rep_cnt + 1'b1;
   assign req = (level & ~level_q) | rep_req;
`else
   assign req = level & ~level_q;
`endif

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state    <= IDLE;
         lock_cnt <= '0;
         pending  <= 1'b0;
         level_q  <= 1'b0;
      end else begin
         state    <= state_nx;
         lock_cnt <= lock_cnt_nx;
         pending  <= pending_nx;
         level_q  <= level;
      end

   always_comb begin
      state_nx    = state;
      lock_cnt_nx = lock_cnt;
      pending_nx  = 1'b0;
      expire      = state == LOCK && lock_cnt <= LW'(1);
      case (state)
         IDLE: state_nx = req ? FIRE : IDLE;
         FIRE: begin
            state_nx    = LOCK;
            lock_cnt_nx = LW'(LOCKOUT_CYCLES);
         end
         LOCK: begin
            lock_cnt_nx = lock_cnt != '0 ? lock_cnt - 1'b1 : lock_cnt;
            // a request landing on the expiry cycle is still honoured
            if (expire) state_nx = (pending | req) ? FIRE : IDLE;
            else pending_nx = pending | req;
         end
         default: state_nx = IDLE;
      endcase
   end

   assign count   = state == FIRE;
   assign busy    = state == LOCK;
   assign pressed = level;
endmodule

// File: tb/tb_game_select_button.sv
// tb_game_select_button: directed checks of strobe timing, debounce, lockout, pending and reset abort.
// Autorepeat expectations switch on GAME_SELECT_AUTOREPEAT_EN.
module tb_game_select_button;
   logic clk = 1'b0, rst_n = 1'b0, btn_n = 1'b1;
   logic count, busy, pressed, count2, busy2, pressed2;
   int cyc = 0, n_chk = 0, n_pass = 0, busy_cnt = 0, pr_cnt = 0;
   int strobes[$], strobes2[$];

   game_select_button #(.DEBOUNCE_CYCLES(4), .LOCKOUT_CYCLES(8)
`ifdef GAME_SELECT_AUTOREPEAT_EN
      , .REPEAT_DELAY(20), .REPEAT_PERIOD(10)
`endif
   ) dut (.clk(clk), .rst_n(rst_n), .btn_n(btn_n), .count(count), .busy(busy), .pressed(pressed));

   // long lockout so a third press can land while a strobe is already pending
   game_select_button #(.DEBOUNCE_CYCLES(4), .LOCKOUT_CYCLES(30)
`ifdef GAME_SELECT_AUTOREPEAT_EN
      , .REPEAT_DELAY(40), .REPEAT_PERIOD(30)
`endif
   ) dut2 (.clk(clk), .rst_n(rst_n), .btn_n(btn_n), .count(count2), .busy(busy2), .pressed(pressed2));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) begin
      if (count) strobes.push_back(cyc);
      if (count2) strobes2.push_back(cyc);
      if (busy) busy_cnt++;
      if (pressed) pr_cnt++;
   end

   task automatic check(input string tag, input int got, input int exp);
      n_chk++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
   endtask

   task automatic drive(input logic v, input int n);
      btn_n = v;
      repeat (n) @(negedge clk);
   endtask

   function automatic int st(input int i);
      return strobes.size() > i ? strobes[i] : -1;
   endfunction

   function automatic int st2(input int i);
      return strobes2.size() > i ? strobes2[i] : -1;
   endfunction

   initial begin
      int c;
      repeat (3) @(negedge clk);
      check("reset_count", int'(count), 0);
      check("reset_busy", int'(busy), 0);
      check("reset_pressed", int'(pressed), 0);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);

      // clean press
      strobes.delete(); busy_cnt = 0; c = cyc;
      drive(1'b0, 20);
      check("clean_pressed_held", int'(pressed), 1);
      drive(1'b1, 12);
      check("clean_pressed_released", int'(pressed), 0);
      check("clean_strobes", strobes.size(), 1);
      check("clean_strobe_time", st(0), c + 7);
      check("clean_busy_cycles", busy_cnt, 8);

      // glitch shorter than the debounce window
      strobes.delete(); pr_cnt = 0;
      drive(1'b0, 3);
      drive(1'b1, 15);
      check("glitch_strobes", strobes.size(), 0);
      check("glitch_pressed_cycles", pr_cnt, 0);

      // bounce then settle low
      strobes.delete(); c = cyc;
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 2);
         drive(1'b1, 2);
      end
      drive(1'b0, 20);
      drive(1'b1, 15);
      check("bounce_strobes", strobes.size(), 1);
      check("bounce_strobe_time", st(0), c + 19);

      // re-press during LOCK becomes pending; a further press while pending is dropped (dut2)
      strobes.delete(); strobes2.delete(); c = cyc;
      drive(1'b0, 4);
      drive(1'b1, 4);
      drive(1'b0, 12);
      drive(1'b1, 4);
      drive(1'b0, 14);
      drive(1'b1, 40);
      check("pending_strobes", strobes.size(), 3);
      check("pending_first", st(0), c + 7);
      check("pending_after_expiry", st(1), c + 16);
      check("pending_third_idle", st(2), c + 31);
      check("drop_strobes", strobes2.size(), 2);
      check("drop_first", st2(0), c + 7);
      check("drop_second", st2(1), c + 38);

      // press edge on the exact expiry cycle
      strobes.delete(); c = cyc;
      drive(1'b0, 4);
      drive(1'b1, 5);
      drive(1'b0, 16);
      drive(1'b1, 15);
      check("expiry_press_strobes", strobes.size(), 2);
      check("expiry_press_time", st(1), c + 16);

      // reset while LOCK has a pending strobe
      c = cyc;
      drive(1'b0, 4);
      drive(1'b1, 4);
      drive(1'b0, 7);
      check("pre_reset_busy", int'(busy), 1);
      strobes.delete();
      rst_n = 1'b0;
      #1;
      check("midreset_count", int'(count), 0);
      check("midreset_busy", int'(busy), 0);
      check("midreset_pressed", int'(pressed), 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1; c = cyc;
      drive(1'b0, 15);
      drive(1'b1, 15);
      check("post_reset_strobes", strobes.size(), 1);
      check("post_reset_time", st(0), c + 7);

      // long hold
      strobes.delete(); c = cyc;
      drive(1'b0, 60);
      drive(1'b1, 30);
`ifdef GAME_SELECT_AUTOREPEAT_EN
      check("hold_strobes", strobes.size(), 5);
      check("hold_t0", st(0), c + 7);
      check("hold_first_repeat", st(1), c + 27);
      check("hold_repeat2", st(2), c + 37);
      check("hold_repeat3", st(3), c + 47);
      check("hold_repeat4", st(4), c + 57);
`else
      check("hold_strobes", strobes.size(), 1);
      check("hold_t0", st(0), c + 7);
`endif
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
